// File: rtl/mul_pkg.sv
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the multi-cycle multiply
//                sequencer: FSM state encoding, default width, counter width
//                and the MUL instruction encoding used by the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  // Default operand/result width; the sequencer runs one iteration per bit.
  localparam int MUL_N = 64;

  // Iteration counter width: one extra bit so the count reaches N without wrap.
  function automatic int mul_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int MUL_CNT_W = mul_cnt_width(MUL_N);

  // MUL encoding (RV M-extension) the decoder matches to raise start.
  localparam logic [6:0] MUL_OPCODE = 7'b0110011;
  localparam logic [2:0] MUL_FUNCT3 = 3'b000;
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage : mul_pkg

`default_nettype wire

// File: rtl/mul_sequencer_adder.sv
// ============================================================================
//  Module      : mul_sequencer_adder
//  Description : Plain W-bit adder reused for the multiply accumulator.
//                Carry-out is dropped; the sum wraps modulo 2^W.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sequencer_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  // Modular sum; the product is defined on the low W bits only.
  always_comb begin
    sum_o = a_i + b_i;
  end

endmodule : mul_sequencer_adder

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
//  Module      : mul_sequencer
//  Description : Shift-add multiply controller for the execute stage. Holds
//                the pipeline stalled while a MUL iterates, then pulses done
//                for one cycle with the low N bits of the product.
//                Optional macro MUL_EARLY_TERM_EN: leave BUSY as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sequencer
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CNT_W = mul_cnt_width(N);

  mul_state_t         state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       acc_sum;
  logic               last_iter;
  logic               iterate;

  mul_sequencer_adder #(.W(N)) accadd (
    .a_i   (acc_q),
    .b_i   (a_q),
    .sum_o (acc_sum)
  );

  assign last_iter = (cnt_q == CNT_W'(N - 1));

`ifdef MUL_EARLY_TERM_EN
  // An exhausted multiplier means the product is already final.
  assign iterate = (state_q == BUSY) && (b_q != '0);
`else
  assign iterate = (state_q == BUSY);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
`ifdef MUL_EARLY_TERM_EN
      BUSY: if (last_iter || (b_q == '0)) state_d = DONE;
`else
      BUSY: if (last_iter) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; forced low during reset so an aborted multiply never retires.
  always_comb begin
    stall  = !reset && (((state_q == IDLE) && start) || (state_q == BUSY));
    done   = !reset && (state_q == DONE);
    result = acc_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Datapath next state: load on accept, one shift-add step per BUSY cycle.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if ((state_q == IDLE) && start) begin
      a_d   = op_a;
      b_d   = op_b;
      acc_d = '0;
      cnt_d = '0;
    end else if (iterate) begin
      if (b_q[0]) acc_d = acc_sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule : mul_sequencer

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Directed self-checking bench for mul_sequencer (N=64).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sequencer;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         stall;
  logic         done;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle index (from the accepting IDLE cycle) at which done is expected.
  function automatic int exp_lat(input logic [N-1:0] b);
    int lat;
    lat = N + 1;
`ifdef MUL_EARLY_TERM_EN
    if (b == '0) begin
      lat = 2;
    end else begin
      for (int i = 0; i < N; i++) if (b[i]) lat = i + 3;
      if (lat > N + 1) lat = N + 1;
    end
`endif
    return lat;
  endfunction

  // One multiply: inputs presented at the next negedge (cycle 0), then the
  // bench waits for done, checking stall and timing along the way.
  task automatic mul_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp, input bit hold);
    int lat;
    int got;
    int stall_low;
    lat = exp_lat(b);
    got = 0;
    stall_low = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    #1;
    check({tag, "_stall_c0"}, N'(stall), N'(1));
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        check({tag, "_latency"}, N'(c), N'(lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_done"}, N'(stall), N'(0));
        got = 1;
        break;
      end
      if (!stall) stall_low++;
    end
    check({tag, "_done_seen"}, N'(got), N'(1));
    check({tag, "_stall_busy"}, N'(stall_low), N'(0));
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", N'(stall), N'(0));
    check("rst_done", N'(done), N'(0));
    reset = 1'b0;
    #1;
    check("rst_result", result, '0);
    check("rst_stall_after", N'(stall), N'(0));

    mul_op("m3x5", 64'd3, 64'd5, 64'd15, 1'b0);
    mul_op("trunc", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    mul_op("neg7x6", 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    mul_op("big", 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001,
           64'h1234_5678_9ABC_DEF0, 1'b0);

    // Back-to-back with start held through the DONE cycle.
    mul_op("b2b_1", 64'd3, 64'd5, 64'd15, 1'b1);
    check("b2b_result_hold", result, 64'd15);
    mul_op("b2b_2", 64'd4, 64'd4, 64'd16, 1'b0);

    // Operand patterns that shorten latency when early termination is on.
    mul_op("b_zero", 64'd77, 64'd0, 64'd0, 1'b0);
    mul_op("b_one", 64'd9, 64'd1, 64'd9, 1'b0);

    // Reset part way through a multiply.
    @(negedge clk);
    op_a  = 64'd3;
    op_b  = 64'd5;
    start = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_stall_busy", N'(stall), N'(1));
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("abort_stall_rst", N'(stall), N'(0));
    check("abort_done_rst", N'(done), N'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_result", result, '0);
    check("abort_stall", N'(stall), N'(0));
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort_no_done", N'(seen), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mul_sequencer

`default_nettype wire

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle integer multiply controller for the pipeline's execute stage. On a MUL instruction in execute it freezes the pipeline and runs a shift-add multiply over N iterations. It then presents the low N bits of the product for exactly one cycle, alongside the ALU result path. It owns the stall request for the front-end and execute pipeline registers while a multiply is in flight.

## Interface
Parameters:
- N, 64, operand and result width; iteration count equals N.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  execute stage holds a decoded MUL; level, held by the frozen pipeline.
- op_a  input  N  multiplicand (readData1_E).
- op_b  input  N  multiplier (readData2_E).
- stall  output  1  freeze PC, IF/ID and ID/EX registers; hold EX/MEM as bubble.
- done  output  1  one-cycle pulse: result valid, pipeline advances this cycle.
- result  output  N  low N bits of op_a*op_b, unsigned (identical for two's complement).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1: load a_reg=op_a, b_reg=op_b, acc=0, cnt=0; next state BUSY.
  - start=0: remain IDLE.
- BUSY, one iteration per cycle:
  - if b_reg[0]: acc <= acc + a_reg (mod 2^N).
  - a_reg <= a_reg << 1; b_reg <= b_reg >> 1; cnt <= cnt+1.
  - When cnt==N-1 this cycle, next state DONE.
- DONE: done=1; next state IDLE unconditionally. start is ignored in DONE.
- Accumulate carry-out is discarded.
- start is ignored in BUSY.
- cnt width is clog2(N)+1 and never wraps.
- stall = (state==IDLE && start) || state==BUSY. It is combinational from start in IDLE. It is 0 in DONE, so the MUL retires that cycle.
- result = acc register. It holds the last product until the next load clears it.
- Back-to-back MUL: start still high in the cycle after DONE is accepted from IDLE normally.
- Reset, including mid-operation: state=IDLE, acc=0, a_reg=b_reg=0, cnt=0. done=0 and stall=0 while reset is high. An aborted multiply never produces done.

## Timing
- Cycle 0: IDLE with start=1; stall=1.
- Cycles 1..N: BUSY; stall=1.
- Cycle N+1: DONE; done=1, stall=0, result valid.
- Stall is asserted for N+1 cycles. Start-to-done latency is N+1 cycles (65 for N=64).
- A new multiply can begin at cycle N+2.
- Outputs after reset: stall=0, done=0, result=0.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - In BUSY, if b_reg==0 at the start of the cycle, skip the iteration and go to DONE next cycle. The product is already complete.
  - Latency becomes (index of highest set bit of op_b) + 3 cycles, with op_b=0 giving 2 cycles.
  - The cnt==N-1 exit still applies.
- Undefined: fixed latency of N+1 cycles regardless of operands.

## Structure
- Shared package mul_pkg:
  - state enum mul_state_t {IDLE, BUSY, DONE}.
  - localparam MUL_N=64.
  - counter width constant.
  - the MUL opcode constant used by the decoder to drive start.
- Sub-module: reuse the existing adder for acc + a_reg, instantiated as accadd. Everything else is inline in mul_sequencer.

## Test plan
- Reset, then op_a=3, op_b=5, start=1 -> stall high for cycles 0..64; done=1 only in cycle 65 with result=15; stall=0 in cycle 65.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> result=0xFFFF_FFFF_FFFF_FFFE (truncation, carry discarded).
- op_a=−7 (0xFFFF_FFFF_FFFF_FFF9), op_b=6 -> result=0xFFFF_FFFF_FFFF_FFD6 (−42).
- Back-to-back: 3×5 then 4×4 with start held -> two done pulses 66 cycles apart with results 15 then 16; start ignored during the DONE cycle.
- Reset asserted at cycle 30 of a multiply -> next cycle state IDLE, stall=0, result=0; done never pulses.
- MUL_EARLY_TERM_EN: op_b=0 -> done at cycle 2 with result=0. op_b=1, op_a=9 -> done at cycle 3 with result=9. Without the macro, both cases give done at cycle 65.
